// File: rtl/idecode.sv
// idecode: decode stage with bypassed regfile, load-use bubble and branch squash
module idecode #(
    parameter int WORD = 32,
    parameter int ADDR = 16,
    parameter int REGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            v_i,
    input  logic [WORD-1:0] inst_i,
    input  logic [ADDR-1:0] pc_i,
    input  logic            stall_i,
    input  logic            branch_i,
    input  logic            wb_we_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [WORD-1:0] wb_data_i,
    output logic            stall_o,
    output logic            v_o,
    output logic [5:0]      op_o,
    output logic [4:0]      rd_o,
    output logic [WORD-1:0] a_o,
    output logic [WORD-1:0] b_o,
    output logic [WORD-1:0] imm_o,
    output logic [ADDR-1:0] pc_o,
    output logic            we_o,
    output logic            ld_o,
    output logic            st_o,
    output logic            br_o,
    output logic            ill_o
);
    typedef struct packed {
        logic            v;
        logic [5:0]      op;
        logic [4:0]      rd;
        logic [WORD-1:0] a;
        logic [WORD-1:0] b;
        logic [WORD-1:0] imm;
        logic [ADDR-1:0] pc;
        logic            we;
        logic            ld;
        logic            st;
        logic            br;
        logic            ill;
    } bundle_t;
    logic [WORD-1:0] rf_q [REGS];
    logic [WORD-1:0] rf_d [REGS];
    bundle_t bun_q, bun_d, dec;
    logic [5:0] op;
    logic [4:0] rd, rs, rt, bsel;
    logic alu, addi, ldi, sti, beq, jmp, use_rs, use_b, luse;
    always_comb begin
        op = inst_i[31:26];
        rd = inst_i[25:21];
        rs = inst_i[20:16];
        rt = inst_i[15:11];
        alu = op == 6'd0;
        addi = op == 6'd1;
        ldi = op == 6'd2;
        sti = op == 6'd3;
        beq = op == 6'd4;
        jmp = op == 6'd5;
        use_rs = alu | addi | ldi | sti | beq;
        use_b = alu | sti | beq;
        bsel = alu ? rt : rd;
        // only sources the opcode actually reads may raise a load-use hazard
        luse = bun_q.v & bun_q.ld & (bun_q.rd != 5'd0) & v_i &
               ((use_rs & (rs == bun_q.rd)) | (use_b & (bsel == bun_q.rd)));
        dec = '0;
        dec.v = v_i;
        dec.op = op;
        dec.rd = rd;
        dec.a = (rs == 5'd0) ? '0 : (wb_we_i && wb_rd_i == rs) ? wb_data_i : rf_q[rs];
        dec.b = (!use_b || bsel == 5'd0) ? '0 :
                (wb_we_i && wb_rd_i == bsel) ? wb_data_i : rf_q[bsel];
        dec.imm = {{(WORD-16){inst_i[15]}}, inst_i[15:0]};
        dec.pc = pc_i - ADDR'(1);
        dec.we = (alu | addi | ldi) & (rd != 5'd0);
        dec.ld = ldi;
        dec.st = sti;
        dec.br = beq | jmp;
        dec.ill = op > 6'd5;
        bun_d = branch_i ? '0 : stall_i ? bun_q : luse ? '0 : dec;
        stall_o = stall_i | (luse & ~branch_i);
        rf_d = rf_q;
        if (wb_we_i && wb_rd_i != 5'd0) rf_d[wb_rd_i] = wb_data_i;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bun_q <= '0;
            for (int i = 0; i < REGS; i++) rf_q[i] <= '0;
        end else begin
            bun_q <= bun_d;
            rf_q <= rf_d;
        end
    end
    assign v_o = bun_q.v;
    assign op_o = bun_q.op;
    assign rd_o = bun_q.rd;
    assign a_o = bun_q.a;
    assign b_o = bun_q.b;
    assign imm_o = bun_q.imm;
    assign pc_o = bun_q.pc;
    assign we_o = bun_q.we;
    assign ld_o = bun_q.ld;
    assign st_o = bun_q.st;
    assign br_o = bun_q.br;
    assign ill_o = bun_q.ill;
endmodule

// File: tb/tb_idecode.sv
// tb_idecode: randomized scoreboard bench for idecode against a behavioural model
module tb_idecode;
    logic clk = 0, rst = 0;
    logic v_i = 0, stall_i = 0, branch_i = 0, wb_we_i = 0;
    logic [31:0] inst_i = 0, wb_data_i = 0;
    logic [15:0] pc_i = 0;
    logic [4:0] wb_rd_i = 0;
    logic stall_o, v_o, we_o, ld_o, st_o, br_o, ill_o;
    logic [5:0] op_o;
    logic [4:0] rd_o;
    logic [31:0] a_o, b_o, imm_o;
    logic [15:0] pc_o;

    always #5 clk = ~clk;

    idecode #(.WORD(32), .ADDR(16), .REGS(32)) dut (
        .clk(clk), .rst(rst), .v_i(v_i), .inst_i(inst_i), .pc_i(pc_i),
        .stall_i(stall_i), .branch_i(branch_i), .wb_we_i(wb_we_i),
        .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i), .stall_o(stall_o),
        .v_o(v_o), .op_o(op_o), .rd_o(rd_o), .a_o(a_o), .b_o(b_o),
        .imm_o(imm_o), .pc_o(pc_o), .we_o(we_o), .ld_o(ld_o), .st_o(st_o),
        .br_o(br_o), .ill_o(ill_o)
    );

    typedef struct packed {
        logic v;
        logic [5:0] op;
        logic [4:0] rd;
        logic [31:0] a, b, imm;
        logic [15:0] pc;
        logic we, ld, st, br, ill;
    } exp_t;

    exp_t q[$];
    exp_t mb = '0;
    logic [31:0] regs [32];
    logic last_luse = 0;
    int checks = 0, fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rreg(input logic [4:0] i);
        if (i == 0) return 0;
        if (wb_we_i && wb_rd_i == i) return wb_data_i;
        return regs[i];
    endfunction

    function automatic logic [31:0] mk(input int op, input int rd, input int rs, input int imm);
        return {op[5:0], rd[4:0], rs[4:0], imm[15:0]};
    endfunction

    // One clock edge of stimulus; the model predicts what the bundle shows after it.
    task automatic step(input logic v, input logic [31:0] inst, input logic [15:0] pc,
                        input logic st = 0, input logic br = 0, input logic we = 0,
                        input logic [4:0] wrd = 0, input logic [31:0] wd = 0);
        exp_t n;
        logic [5:0] op;
        logic [4:0] rd, rs, rt, bs;
        logic urs, ub, luse;
        @(negedge clk);
        v_i = v; inst_i = inst; pc_i = pc; stall_i = st; branch_i = br;
        wb_we_i = we; wb_rd_i = wrd; wb_data_i = wd;
        #1;
        op = inst[31:26]; rd = inst[25:21]; rs = inst[20:16]; rt = inst[15:11];
        urs = op <= 4;
        ub = op == 0 || op == 3 || op == 4;
        bs = (op == 0) ? rt : rd;
        luse = mb.v && mb.ld && mb.rd != 0 && v && ((urs && rs == mb.rd) || (ub && bs == mb.rd));
        last_luse = luse;
        chk("stall_o", stall_o, st | (luse & ~br));
        if (br || (!st && luse)) mb.v = 0;
        else if (!st) begin
            n = '0;
            n.v = v; n.op = op; n.rd = rd;
            n.a = rreg(rs);
            n.b = ub ? rreg(bs) : 0;
            n.imm = {{16{inst[15]}}, inst[15:0]};
            n.pc = pc - 16'd1;
            n.we = op <= 2 && rd != 0;
            n.ld = op == 2; n.st = op == 3; n.br = op == 4 || op == 5; n.ill = op > 5;
            mb = n;
        end
        q.push_back(mb);
        if (we && wrd != 0) regs[wrd] = wd;
    endtask

    task automatic do_reset;
        @(posedge clk);
        #3;
        v_i = 0; stall_i = 0; branch_i = 0; wb_we_i = 0; inst_i = 0; pc_i = 0;
        wb_rd_i = 0; wb_data_i = 0;
        rst = 0;
        #1;
        chk("rst_v_o", v_o, 0);
        chk("rst_a_o", a_o, 0);
        chk("rst_b_o", b_o, 0);
        chk("rst_imm_o", imm_o, 0);
        chk("rst_fields", {op_o, rd_o, pc_o, we_o, ld_o, st_o, br_o, ill_o}, 0);
        chk("rst_stall_o", stall_o, 0);
        mb = '0;
        foreach (regs[i]) regs[i] = 0;
        last_luse = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
    endtask

    task automatic step_until_issued(input logic [31:0] inst, input logic [15:0] pc);
        step(1, inst, pc);
        if (last_luse) step(1, inst, pc);
    endtask

    initial begin : monitor
        logic r;
        exp_t e;
        forever begin
            @(posedge clk);
            r = rst;
            #2;
            if (r) begin
                if (q.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL scoreboard_empty: got v_o=%0b with nothing expected", v_o);
                end else begin
                    e = q.pop_front();
                    chk("v_o", v_o, e.v);
                    if (e.v) begin
                        chk("op_o", op_o, e.op);
                        chk("rd_o", rd_o, e.rd);
                        chk("a_o", a_o, e.a);
                        chk("b_o", b_o, e.b);
                        chk("imm_o", imm_o, e.imm);
                        chk("pc_o", pc_o, e.pc);
                        chk("flags", {we_o, ld_o, st_o, br_o, ill_o}, {e.we, e.ld, e.st, e.br, e.ill});
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    initial begin : driver
        logic [31:0] inst;
        logic [5:0] op;
        int r;
        foreach (regs[i]) regs[i] = 0;
        do_reset;
        step(1, 32'h04200005, 16'h0001);
        step(0, 0, 0, 0, 0, 1, 1, 5);
        step(1, mk(0, 4, 3, 3 << 11), 2, 0, 0, 1, 3, 32'hDEADBEEF);
        step(1, mk(0, 5, 3, 3 << 11), 3);
        step(1, mk(2, 2, 1, 0), 4);
        step(1, mk(0, 5, 2, 1 << 11), 5);
        step(1, mk(0, 5, 2, 1 << 11), 5);
        step(1, mk(2, 2, 1, 0), 6);
        step(1, mk(1, 6, 1, 7), 7);
        step(1, mk(2, 0, 1, 0), 8);
        step(1, mk(0, 7, 0, 0), 9);
        step(0, 0, 0, 0, 0, 1, 0, 32'h123);
        step(1, mk(0, 8, 0, 0), 10);
        step(1, mk(1, 10, 1, 1), 12, 0, 1);
        step(1, mk(1, 11, 1, 9), 13);
        repeat (3) step(1, mk(1, 12, 1, 1), 14, 1);
        step(0, 0, 0);
        step(1, 32'hFFFFFFFF, 15);
        step(1, mk(1, 1, 1, 16'h8000), 16);
        step(1, mk(1, 2, 0, 1), 16'h0000);
        step_until_issued(mk(2, 1, 0, 0), 20);
        step_until_issued(mk(2, 2, 1, 0), 21);
        step_until_issued(mk(0, 3, 2, 2 << 11), 22);
        inst = 0;
        for (int i = 0; i < 900; i++) begin
            if (i == 600) begin
                do_reset;
                for (int k = 1; k < 8; k++) step(1, mk(0, 8, k, k << 11), 16'(k));
            end
            if (!last_luse || $urandom_range(0, 3) == 0) begin
                r = $urandom_range(0, 8);
                op = (r <= 5) ? 6'(r) : (r == 6) ? 6'h3F : 6'($urandom_range(6, 62));
                inst = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                        5'($urandom_range(0, 7)), 11'($urandom)};
            end
            r = $urandom_range(0, 5);
            step($urandom_range(0, 4) != 0, inst, 16'($urandom), r == 0,
                 r != 0 && $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), $urandom);
        end
        step(0, 0, 0);
        @(posedge clk);
        #3;
        chk("queue_drain", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
